tetris_button_conditioner: RTL and testbench
============================================

# tetris_button_conditioner

Input-side front end for the tetris game. Converts the four raw push-buttons (left, right, change, down) into clean signals for the game logic: synchronized and debounced levels, one-cycle press pulses with hold-to-repeat, and one-cycle release pulses. It sits between the board button pins and the game core's `left/right/change/down` inputs. Everything runs in the 50 MHz `CLK` domain, so the game core samples clean edges instead of raw bouncing contacts.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive mismatching synchronized samples required to flip a debounced level (10 ms at 50 MHz). Must be ≥2.
- `REPEAT_DELAY`, default 20000000: cycles from the press pulse to the first auto-repeat pulse (400 ms). Must be ≥2.
- `REPEAT_PERIOD`, default 5000000: cycles between consecutive auto-repeat pulses (100 ms). Must be ≥2.
- `CLK` input 1: system clock, 50 MHz. All logic is on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `btn_raw` input 4: raw buttons, active-high, asynchronous. Bit 0 left, bit 1 right, bit 2 change, bit 3 down.
- `repeat_en` input 4: per-button auto-repeat enable. The game ties bit 2 (change) low. Treated as quasi-static.
- `btn_level` output 4: debounced level per button.
- `btn_press` output 4: one-cycle pulse on each debounced press and on each auto-repeat.
- `btn_release` output 4: one-cycle pulse on each debounced release.
- `any_press` output 1: registered OR of the `btn_press` logic, asserted in the same cycle as the pulse.

## Operation
- Synchronizer: two flops per bit, `s1` then `s2`. Reset value 0.
- Debounce, per bit, with counter `dcnt` of width clog2(DEBOUNCE_CYCLES):
  - If `s2 == btn_level`, `dcnt` is set to 0.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`, `btn_level` takes the value of `s2` and `dcnt` is set to 0.
  - Else `dcnt` increments.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES edges never changes the level.
- Per-button FSM with states IDLE, HOLD and REPEAT, plus counter `rcnt` (width clog2(max(REPEAT_DELAY, REPEAT_PERIOD))):
  - IDLE: when the level rises, pulse `btn_press`, go to HOLD with `rcnt` = 0.
  - HOLD: `rcnt` increments. When `rcnt == REPEAT_DELAY-1`: if `repeat_en` is high, pulse `btn_press`; then go to REPEAT with `rcnt` = 0. If `repeat_en` is low, `rcnt` stays at REPEAT_DELAY-1 with no pulse, and the FSM stays in HOLD.
  - REPEAT: `rcnt` increments. When `rcnt == REPEAT_PERIOD-1`, pulse `btn_press` and set `rcnt` to 0. If `repeat_en` goes low, pulses stop and the counter keeps running.
  - Any state: when the level falls, pulse `btn_release`, go to IDLE, set `rcnt` to 0.
- Left/right conflict: while `btn_level[0]` and `btn_level[1]` are both high, auto-repeat pulses for bits 0 and 1 are dropped. Their FSMs and counters continue normally. Initial press pulses are never suppressed.
- `btn_press`, `btn_release` and `any_press` are registered and default to 0 in every cycle in which they are not pulsed.

## Timing
- Reset values: all outputs 0, `s1`/`s2` 0, all counters 0, all FSMs IDLE. Reset takes effect immediately and asynchronously; outputs drop mid-pulse.
- Reset mid-hold: a button still held at reset release counts as a new press. The press pulse follows the normal latency.
- Press latency: take the first edge sampling `btn_raw` = 1 as edge 0. `btn_level` and `btn_press` go high after edge DEBOUNCE_CYCLES+1.
- Release latency: identical, measured to `btn_release`.
- First repeat pulse: after edge DEBOUNCE_CYCLES+1+REPEAT_DELAY.
- Subsequent repeat pulses: every REPEAT_PERIOD edges after the first.
- Release in the same cycle a repeat pulse would fire: the release wins. `btn_release` = 1 and `btn_press` = 0.
- Buttons are fully independent except for the left/right conflict rule. Simultaneous presses yield simultaneous pulses.
- Pulse width is exactly 1 cycle. Two `btn_press` pulses on the same bit are never closer than 2 cycles.

## Test plan
All scenarios use parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, with `repeat_en` = 4'b1011.

1. Reset: assert `RST` asynchronously mid-cycle while `btn_level` = 4'b0001 → all outputs read 0 before the next edge. Release `RST` with bit 0 still held → `btn_press[0]` after edge 5 relative to the first sampling edge.
2. Bounce filter: toggle `btn_raw[3]` at 1,1,1,0,1,1,1,1 per edge → no level change during the 3-high burst. `btn_level[3]` and `btn_press[3]` rise exactly 5 edges after the stable-high run starts.
3. Auto-repeat: hold `btn_raw[0]` from edge 0 through edge 24 → `btn_press[0]` pulses after edges 5, 15, 18 and 21, plus 24 if the level is still high. Release → `btn_release[0]` 5 edges after the first low sample, with no press in that cycle.
4. Repeat disabled: hold `btn_raw[2]` for 40 edges → exactly one `btn_press[2]` (after edge 5) and one release pulse.
5. Left/right conflict: hold left from edge 0, and add right from edge 2 until edge 30 → press pulses for bit 0 after edge 5 and for bit 1 after edge 7. No repeat pulses on bits 0 or 1 until one of them releases.
6. Simultaneous presses: raise all four bits on the same edge → `btn_press` = 4'b1111 and `any_press` = 1 in the same single cycle.

Source files
------------

// File: rtl/tetris_button_conditioner.sv
// Button front end: synchronizes and debounces the four raw buttons, then
// produces one-cycle press pulses (with hold-to-repeat) and release pulses.
module tetris_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 20000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] btn_raw,
   input  logic [3:0] repeat_en,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release,
   output logic       any_press
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX);

   localparam logic [DW-1:0] D_LAST      = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

   logic [3:0]    s1;
   logic [3:0]    s2;
   logic [DW-1:0] dcnt [4];
   rep_state_t    state [4];
   logic [RW-1:0] rcnt [4];

   logic [3:0] level_next;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] rep_fire;
   logic [3:0] press_next;
   logic       conflict;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // Level flips on the edge where the mismatch count is already full, so the
   // FSMs below see the new level in the same cycle it is registered.
   always_comb begin
      level_next = btn_level;
      for (int i = 0; i < 4; i++) begin
         if (s2[i] != btn_level[i] && dcnt[i] == D_LAST)
            level_next[i] = s2[i];
      end
   end

   assign rise     = level_next & ~btn_level;
   assign fall     = ~level_next & btn_level;
   assign conflict = level_next[0] & level_next[1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         btn_level <= '0;
         for (int i = 0; i < 4; i++)
            dcnt[i] <= '0;
      end else begin
         btn_level <= level_next;
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == btn_level[i] || dcnt[i] == D_LAST)
               dcnt[i] <= '0;
            else
               dcnt[i] <= dcnt[i] + 1'b1;
         end
      end
   end

   // Auto-repeat pulses are masked by left/right conflict and by a release,
   // while the initial press pulse from a rising level is never masked.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < 4; i++) begin
         case (state[i])
            HOLD:    rep_fire[i] = repeat_en[i] && (rcnt[i] == DELAY_LAST);
            REPEAT:  rep_fire[i] = repeat_en[i] && (rcnt[i] == PERIOD_LAST);
            default: rep_fire[i] = 1'b0;
         endcase
      end
      if (conflict)
         rep_fire[1:0] = 2'b00;
      press_next = rise | (rep_fire & ~fall);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         btn_press   <= '0;
         btn_release <= '0;
         any_press   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            state[i] <= IDLE;
            rcnt[i]  <= '0;
         end
      end else begin
         btn_press   <= press_next;
         btn_release <= fall;
         any_press   <= |press_next;
         for (int i = 0; i < 4; i++) begin
            if (fall[i]) begin
               state[i] <= IDLE;
               rcnt[i]  <= '0;
            end else begin
               case (state[i])
                  IDLE: begin
                     if (rise[i]) begin
                        state[i] <= HOLD;
                        rcnt[i]  <= '0;
                     end
                  end
                  HOLD: begin
                     // With repeat disabled the counter parks at the delay limit.
                     if (rcnt[i] == DELAY_LAST) begin
                        if (repeat_en[i]) begin
                           state[i] <= REPEAT;
                           rcnt[i]  <= '0;
                        end
                     end else begin
                        rcnt[i] <= rcnt[i] + 1'b1;
                     end
                  end
                  REPEAT: begin
                     if (rcnt[i] == PERIOD_LAST)
                        rcnt[i] <= '0;
                     else
                        rcnt[i] <= rcnt[i] + 1'b1;
                  end
                  default: begin
                     state[i] <= IDLE;
                     rcnt[i]  <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_tetris_button_conditioner.sv
// Scoreboard bench: a window-based debounce and elapsed-time repeat model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_tetris_button_conditioner;

   localparam int DEB  = 4;
   localparam int RDEL = 10;
   localparam int RPER = 3;
   localparam logic [3:0] EN_DEFAULT = 4'b1011;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] btn_raw;
   logic [3:0] repeat_en;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;
   logic       any_press;

   int check_count = 0;
   int fail_count  = 0;

   logic [12:0] exp_q [$];
   logic [12:0] exp_v;
   logic [3:0]  raw_hist [$];
   logic [3:0]  m_level;
   int          press_edge [4];

   tetris_button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY(RDEL),
      .REPEAT_PERIOD(RPER)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .btn_raw(btn_raw),
      .repeat_en(repeat_en),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .any_press(any_press)
   );

   always #5 CLK = ~CLK;

   // Compares one packed {level, press, release, any} word against expectation.
   task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] expv);
      check_count++;
      if (act !== expv) begin
         fail_count++;
         $display("[TB] FAIL %s at %0t: got level=%b press=%b release=%b any=%b, expected level=%b press=%b release=%b any=%b",
                  name, $time, act[12:9], act[8:5], act[4:1], act[0],
                  expv[12:9], expv[8:5], expv[4:1], expv[0]);
      end
   endtask

   task automatic modelReset();
      raw_hist.delete();
      m_level = '0;
      for (int b = 0; b < 4; b++)
         press_edge[b] = 0;
   endtask

   // Level flips once the last DEB synchronized samples (raw delayed two
   // edges) all disagree with it; repeats fall at fixed times after the press.
   task automatic modelEdge(input logic [3:0] raw, input logic [3:0] en);
      logic [3:0] new_level;
      logic [3:0] press;
      logic [3:0] rel;
      logic       flip;
      logic       s2v;
      logic [3:0] past;
      int         k;
      int         idx;
      int         n;
      raw_hist.push_back(raw);
      k = raw_hist.size() - 1;
      new_level = m_level;
      for (int b = 0; b < 4; b++) begin
         flip = 1'b1;
         for (int j = 0; j < DEB; j++) begin
            idx = k - j;
            if (idx >= 2) begin
               past = raw_hist[idx-2];
               s2v  = past[b];
            end else begin
               s2v = 1'b0;
            end
            if (s2v == m_level[b])
               flip = 1'b0;
         end
         if (flip)
            new_level[b] = ~m_level[b];
      end
      press = '0;
      rel   = '0;
      for (int b = 0; b < 4; b++) begin
         if (new_level[b] && !m_level[b]) begin
            press[b]      = 1'b1;
            press_edge[b] = k;
         end else if (!new_level[b] && m_level[b]) begin
            rel[b] = 1'b1;
         end else if (new_level[b]) begin
            n = k - press_edge[b];
            if (en[b] && (n == RDEL || (n > RDEL && ((n - RDEL) % RPER) == 0))
                && !(b < 2 && new_level[0] && new_level[1]))
               press[b] = 1'b1;
         end
      end
      m_level = new_level;
      exp_q.push_back({new_level, press, rel, |press});
   endtask

   // Drives one cycle of inputs, lets the edge happen, then records the prediction.
   task automatic applyStimulus(input logic [3:0] raw, input logic [3:0] en);
      btn_raw   = raw;
      repeat_en = en;
      @(posedge CLK);
      if (RST)
         exp_q.push_back('0);
      else
         modelEdge(raw, en);
      #1;
   endtask

   task automatic holdFor(input logic [3:0] raw, input logic [3:0] en, input int cycles);
      for (int i = 0; i < cycles; i++)
         applyStimulus(raw, en);
   endtask

   task automatic doReset(input logic [3:0] raw);
      exp_q.delete();
      RST = 1'b1;
      #1;
      checkOutput("async_reset", {btn_level, btn_press, btn_release, any_press}, 13'b0);
      modelReset();
      holdFor(raw, EN_DEFAULT, 2);
      RST = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checkOutput("cycle", {btn_level, btn_press, btn_release, any_press}, exp_v);
      end
   end

   initial begin
      logic [3:0] cur;
      logic [3:0] en;
      RST       = 1'b1;
      btn_raw   = '0;
      repeat_en = EN_DEFAULT;
      modelReset();
      holdFor(4'b0000, EN_DEFAULT, 2);
      RST = 1'b0;

      // Reset lands while the left press pulse is high, then the held button re-presses.
      holdFor(4'b0001, EN_DEFAULT, 6);
      doReset(4'b0001);
      holdFor(4'b0001, EN_DEFAULT, 12);
      holdFor(4'b0000, EN_DEFAULT, 10);

      // Bounce on the down button.
      holdFor(4'b1000, EN_DEFAULT, 3);
      holdFor(4'b0000, EN_DEFAULT, 1);
      holdFor(4'b1000, EN_DEFAULT, 8);
      holdFor(4'b0000, EN_DEFAULT, 10);

      // Auto-repeat on left, release coinciding with a would-be repeat.
      holdFor(4'b0001, EN_DEFAULT, 25);
      holdFor(4'b0000, EN_DEFAULT, 10);

      // Change button with repeat disabled.
      holdFor(4'b0100, EN_DEFAULT, 40);
      holdFor(4'b0000, EN_DEFAULT, 10);

      // Left/right conflict.
      holdFor(4'b0001, EN_DEFAULT, 2);
      holdFor(4'b0011, EN_DEFAULT, 29);
      holdFor(4'b0001, EN_DEFAULT, 12);
      holdFor(4'b0000, EN_DEFAULT, 10);

      // Simultaneous presses.
      holdFor(4'b1111, EN_DEFAULT, 8);
      holdFor(4'b0000, EN_DEFAULT, 10);

      // Random bouncy traffic; repeat_en changes only once everything is idle.
      for (int round = 0; round < 3; round++) begin
         en  = (round == 0) ? EN_DEFAULT : 4'($urandom_range(0, 15));
         cur = '0;
         for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
               if ($urandom_range(0, 99) < 12)
                  cur[b] = ~cur[b];
            end
            applyStimulus(cur, en);
         end
         holdFor(4'b0000, en, 12);
      end

      @(negedge CLK);
      #1;
      if (exp_q.size() != 0) begin
         check_count++;
         fail_count++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
